// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory bridge: access-size
// encodings, bridge FSM states, bus widths and the load-data alignment helper.
package dmem_bus_pkg;

  localparam int unsigned MASK_WIDTH     = 2;
  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH     = 4;

  localparam logic [MASK_WIDTH-1:0] MASK_BYTE = 2'b00;
  localparam logic [MASK_WIDTH-1:0] MASK_HALF = 2'b01;
  localparam logic [MASK_WIDTH-1:0] MASK_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } dmem_state_e;

  // Bring the addressed lane down to bit 0 and zero the bytes above the access size.
  function automatic logic [REG_DATA_WIDTH-1:0] load_align(
    input logic [REG_DATA_WIDTH-1:0] rdata,
    input logic [1:0]                off,
    input logic [MASK_WIDTH-1:0]     mask
  );
    logic [REG_DATA_WIDTH-1:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (mask)
      MASK_BYTE: load_align = {{(REG_DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MASK_HALF: load_align = {{(REG_DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default:   load_align = shifted;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store-side lane alignment: byte strobes, replicated write data and the
// misalignment flag for a byte/half/word access at a given byte offset.
module dmem_lane_align
  import dmem_bus_pkg::*;
(
  input  logic [MASK_WIDTH-1:0]     mask,
  input  logic [1:0]                addr_lo,
  input  logic [REG_DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0]     strb,
  output logic [REG_DATA_WIDTH-1:0] wdata,
  output logic                      misalign
);

  // Decode size/offset into strobes; data is replicated so every lane carries it.
  always_comb begin
    strb     = '0;
    wdata    = wr_data;
    misalign = 1'b0;
    case (mask)
      MASK_BYTE: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{wr_data[7:0]}};
      end
      MASK_HALF: begin
        strb     = 4'b0011 << addr_lo;
        wdata    = {2{wr_data[15:0]}};
        misalign = addr_lo[0];
      end
      default: begin
        strb     = '1;
        wdata    = wr_data;
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's mem-stage load/store port onto a valid/ready request,
// valid response bus. Stalls the core until the access completes.
// Optional response watchdog: define DMEM_RSP_TIMEOUT_EN.
module dmem_bridge
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dmem_rd_en,
  input  logic                      dmem_wr_en,
  input  logic [MASK_WIDTH-1:0]     dmem_mask,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
  input  logic [REG_DATA_WIDTH-1:0] dmem_wr_data,
  output logic [REG_DATA_WIDTH-1:0] dmem_rd_data,
  output logic                      mem_stall,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic                      bus_req_we,
  output logic [MEM_ADDR_WIDTH-1:0] bus_req_addr,
  output logic [REG_DATA_WIDTH-1:0] bus_req_wdata,
  output logic [STRB_WIDTH-1:0]     bus_req_strb,
  input  logic                      bus_rsp_valid,
  input  logic [REG_DATA_WIDTH-1:0] bus_rsp_rdata,
  input  logic                      bus_rsp_err,
  output logic                      bus_err
);

  dmem_state_e               state_q, state_d;
  logic                      we_q, we_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [MASK_WIDTH-1:0]     mask_q, mask_d;
  logic [1:0]                off_q, off_d;
  logic [REG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;

  logic [STRB_WIDTH-1:0]     lane_strb;
  logic [REG_DATA_WIDTH-1:0] lane_wdata;
  logic                      misalign;

`ifdef DMEM_RSP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  dmem_lane_align u_lane_align (
    .mask     (dmem_mask),
    .addr_lo  (dmem_addr[1:0]),
    .wr_data  (dmem_wr_data),
    .strb     (lane_strb),
    .wdata    (lane_wdata),
    .misalign (misalign)
  );

  // Stall is combinational so the core freezes in the cycle the request appears;
  // gated by reset so a held request cannot stall a core that is being reset.
  assign mem_stall     = rst & (dmem_rd_en | dmem_wr_en) & (state_q != ST_DONE);
  assign dmem_rd_data  = rd_data_q;
  assign bus_req_valid = valid_q;
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_strb  = strb_q;
  assign bus_err       = err_q;

  // Next-state and latch updates; rd_data and valid are rebuilt every cycle so
  // they are only non-zero in DONE and REQ respectively.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    mask_d    = mask_q;
    off_d     = off_q;
    rd_data_d = '0;
    err_d     = err_q;
`ifdef DMEM_RSP_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (dmem_rd_en | dmem_wr_en) begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            we_d    = dmem_wr_en;
            addr_d  = {dmem_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
            wdata_d = lane_wdata;
            strb_d  = lane_strb;
            mask_d  = dmem_mask;
            off_d   = dmem_addr[1:0];
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus_req_ready) begin
          state_d = ST_WAIT_RSP;
`ifdef DMEM_RSP_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT_RSP: begin
        if (bus_rsp_valid) begin
          rd_data_d = load_align(bus_rsp_rdata, off_q, mask_q);
          if (bus_rsp_err) err_d = 1'b1;
          state_d = ST_DONE;
        end
`ifdef DMEM_RSP_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_REQ);
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      mask_q    <= '0;
      off_q     <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef DMEM_RSP_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      mask_q    <= mask_d;
      off_q     <= off_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef DMEM_RSP_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized
// accesses compared against a size/offset reference model.
module tb_dmem_bridge;
  import dmem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_rd_en = 1'b0, dmem_wr_en = 1'b0;
  logic [1:0]  dmem_mask = '0;
  logic [31:0] dmem_addr = '0, dmem_wr_data = '0;
  logic [31:0] dmem_rd_data;
  logic        mem_stall, bus_req_valid, bus_req_we, bus_err;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_strb;
  logic        bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit          done;
    int          stall_cycles;
    int          valid_cycles;
    bit          unstable;
    bit          rd_dirty;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd_data;
    logic        err;
    logic [31:0] rd_after;
  } obs_t;

  dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en), .dmem_mask(dmem_mask),
    .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data),
    .mem_stall(mem_stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete within 2ms");
    $fatal(1, "global timeout");
  end

  // Reference: what an access should do, from size and byte offset alone.
  function automatic void ref_model(input logic [1:0] mask, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata,
                                    output bit mis, output logic [3:0] strb,
                                    output logic [31:0] lanes, output logic [31:0] bmask,
                                    output logic [31:0] rd_exp);
    int size, off;
    logic [63:0] m;
    size = (mask == MASK_BYTE) ? 1 : (mask == MASK_HALF) ? 2 : 4;
    off  = int'(addr % 4);
    mis  = (off % size) != 0;
    strb = '0; lanes = '0; bmask = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) begin
        strb[i]        = 1'b1;
        lanes[8*i +: 8] = wdata[8*(i-off) +: 8];
        bmask[8*i +: 8] = 8'hFF;
      end
    end
    m = (64'd1 << (8*size)) - 64'd1;
    rd_exp = mis ? '0 : 32'((64'(rdata) >> (8*off)) & m);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; dmem_rd_en = 1'b0; dmem_wr_en = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one access and plays the bus slave, recording what the DUT did.
  task automatic do_access(input bit rd, input bit wr, input logic [1:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ready_lat, input int rsp_lat,
                           input logic [31:0] rdata, input bit rerr, input bit noise,
                           output obs_t o);
    int  valid_cnt = 0;
    int  wait_cnt  = 0;
    bit  in_wait   = 0;
    o = '{default: '0};
    @(negedge clk);
    dmem_rd_en = rd; dmem_wr_en = wr; dmem_mask = mask;
    dmem_addr = addr; dmem_wr_data = wdata;
    for (int cyc = 0; cyc < 200; cyc++) begin
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
      #1;
      if (mem_stall === 1'b0) begin
        o.done = 1; o.rd_data = dmem_rd_data; o.err = bus_err;
        break;
      end
      o.stall_cycles++;
      if (dmem_rd_data !== '0) o.rd_dirty = 1;
      if (in_wait) begin
        if (wait_cnt >= rsp_lat) begin
          bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata; bus_rsp_err = rerr;
        end
        wait_cnt++;
      end else if (bus_req_valid === 1'b1) begin
        if (valid_cnt == 0) begin
          o.addr = bus_req_addr; o.we = bus_req_we; o.wdata = bus_req_wdata; o.strb = bus_req_strb;
        end else if (bus_req_addr !== o.addr || bus_req_we !== o.we ||
                     bus_req_wdata !== o.wdata || bus_req_strb !== o.strb) begin
          o.unstable = 1;
        end
        valid_cnt++;
        if (valid_cnt > ready_lat) begin
          bus_req_ready = 1'b1; in_wait = 1;
        end else if (noise) begin
          bus_rsp_valid = 1'b1; bus_rsp_rdata = $urandom;
        end
      end else if (noise) begin
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = $urandom;
      end
      @(negedge clk);
    end
    o.valid_cycles = valid_cnt;
    @(negedge clk);
    dmem_rd_en = 1'b0; dmem_wr_en = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    #1;
    o.rd_after = dmem_rd_data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; dmem_rd_en = 1'b1; dmem_mask = MASK_WORD; dmem_addr = 32'h100;
    #1;
    checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", mem_stall); else passes++;
    checks++; if (bus_req_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_req_valid); else passes++;
    checks++; if (dmem_rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0", dmem_rd_data); else passes++;
    checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b expected 0", bus_err); else passes++;
    @(negedge clk);
    dmem_rd_en = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (mem_stall !== 1'b0) $display("FAIL idle_stall: got %b expected 0", mem_stall); else passes++;
    checks++; if (bus_req_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", bus_req_valid); else passes++;
  endtask

  task automatic test_word_load();
    obs_t o;
    do_access(1, 0, MASK_WORD, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0, o);
    checks++; if (!o.done) $display("FAIL word_load_done: got no completion expected completion"); else passes++;
    checks++; if (o.stall_cycles != 3) $display("FAIL word_load_stall: got %0d expected 3", o.stall_cycles); else passes++;
    checks++; if (o.rd_data !== 32'hDEADBEEF) $display("FAIL word_load_rd_data: got %h expected deadbeef", o.rd_data); else passes++;
    checks++; if (o.rd_after !== '0) $display("FAIL word_load_rd_after: got %h expected 0", o.rd_after); else passes++;
    checks++; if (o.addr !== 32'h100 || o.we !== 1'b0) $display("FAIL word_load_req: got addr %h we %b expected 100 0", o.addr, o.we); else passes++;
    checks++; if (o.strb !== 4'b1111) $display("FAIL word_load_strb: got %b expected 1111", o.strb); else passes++;
    checks++; if (o.err !== 1'b0) $display("FAIL word_load_err: got %b expected 0", o.err); else passes++;
  endtask

  task automatic test_byte_store();
    obs_t o;
    do_access(0, 1, MASK_BYTE, 32'h103, 32'h000000A5, 0, 0, 32'h0, 0, 0, o);
    checks++; if (o.strb !== 4'b1000) $display("FAIL byte_store_strb: got %b expected 1000", o.strb); else passes++;
    checks++; if (o.wdata[31:24] !== 8'hA5) $display("FAIL byte_store_wdata: got %h expected a5xxxxxx", o.wdata); else passes++;
    checks++; if (o.addr !== 32'h100) $display("FAIL byte_store_addr: got %h expected 100", o.addr); else passes++;
    checks++; if (o.we !== 1'b1) $display("FAIL byte_store_we: got %b expected 1", o.we); else passes++;
    checks++; if (o.stall_cycles != 3) $display("FAIL byte_store_stall: got %0d expected 3", o.stall_cycles); else passes++;
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_access(1, 0, MASK_HALF, 32'h101, 32'h0, 0, 0, 32'hFFFFFFFF, 0, 0, o);
    checks++; if (o.valid_cycles != 0) $display("FAIL misaligned_valid: got %0d cycles expected 0", o.valid_cycles); else passes++;
    checks++; if (o.err !== 1'b1) $display("FAIL misaligned_err: got %b expected 1", o.err); else passes++;
    checks++; if (o.rd_data !== '0) $display("FAIL misaligned_rd_data: got %h expected 0", o.rd_data); else passes++;
    checks++; if (o.stall_cycles != 1) $display("FAIL misaligned_stall: got %0d expected 1", o.stall_cycles); else passes++;
  endtask

  task automatic test_backpressure();
    obs_t o;
    apply_reset();
    do_access(1, 0, MASK_WORD, 32'h40C, 32'h0, 5, 1, 32'h13579BDF, 0, 0, o);
    checks++; if (o.valid_cycles != 6) $display("FAIL backpressure_valid: got %0d expected 6", o.valid_cycles); else passes++;
    checks++; if (o.unstable) $display("FAIL backpressure_stable: got payload change expected stable"); else passes++;
    checks++; if (o.stall_cycles != 9) $display("FAIL backpressure_stall: got %0d expected 9", o.stall_cycles); else passes++;
    checks++; if (o.rd_data !== 32'h13579BDF) $display("FAIL backpressure_rd_data: got %h expected 13579bdf", o.rd_data); else passes++;
  endtask

  task automatic test_both_enables();
    obs_t o;
    do_access(1, 1, MASK_HALF, 32'h22, 32'h0000BEEF, 0, 0, 32'h0, 0, 0, o);
    checks++; if (o.we !== 1'b1) $display("FAIL both_en_we: got %b expected 1", o.we); else passes++;
    checks++; if (o.strb !== 4'b1100 || o.wdata[31:16] !== 16'hBEEF)
      $display("FAIL both_en_payload: got strb %b wdata %h expected 1100 beefxxxx", o.strb, o.wdata); else passes++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_access(1, 0, MASK_WORD, 32'h202, 32'h0, 0, 0, 32'h0, 0, 0, o);
    checks++; if (bus_err !== 1'b1) $display("FAIL reset_mid_pre_err: got %b expected 1", bus_err); else passes++;
    @(negedge clk);
    dmem_rd_en = 1'b1; dmem_mask = MASK_WORD; dmem_addr = 32'h300;
    @(negedge clk); #1;
    checks++; if (bus_req_valid !== 1'b1) $display("FAIL reset_mid_req: got %b expected 1", bus_req_valid); else passes++;
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus_req_valid !== 1'b0 || mem_stall !== 1'b0)
      $display("FAIL reset_mid_outputs: got valid %b stall %b expected 0 0", bus_req_valid, mem_stall); else passes++;
    checks++; if (dmem_rd_data !== '0 || bus_err !== 1'b0)
      $display("FAIL reset_mid_data: got rd %h err %b expected 0 0", dmem_rd_data, bus_err); else passes++;
    @(negedge clk);
    dmem_rd_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    checks++; if (dmem_rd_data !== '0) $display("FAIL reset_mid_late_rsp: got %h expected 0", dmem_rd_data); else passes++;
    checks++; if (bus_req_valid !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b0)
      $display("FAIL reset_mid_idle: got valid %b stall %b err %b expected 0 0 0", bus_req_valid, mem_stall, bus_err); else passes++;
    do_access(1, 0, MASK_WORD, 32'h500, 32'h0, 0, 0, 32'h12345678, 0, 0, o);
    checks++; if (o.stall_cycles != 3 || o.rd_data !== 32'h12345678)
      $display("FAIL reset_mid_recover: got stall %0d rd %h expected 3 12345678", o.stall_cycles, o.rd_data); else passes++;
  endtask

  task automatic test_random();
    obs_t        o;
    bit          rd, wr, rerr, noise, mis, err_m;
    logic [1:0]  mask;
    logic [31:0] addr, wdata, rdata, lanes, bmask, rd_exp;
    logic [3:0]  strb;
    int          rl, sl, exp_stall;
    err_m = 0;
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 0) begin
        apply_reset();
        err_m = 0;
      end
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1;
      mask  = 2'($urandom_range(0, 2));
      addr  = $urandom; wdata = $urandom;
      rl    = int'($urandom_range(0, 3)); sl = int'($urandom_range(0, 3));
      rdata = wr ? 32'h0 : $urandom;
      rerr  = ($urandom_range(0, 7) == 0);
      noise = 1'($urandom_range(0, 1));
      ref_model(mask, addr, wdata, rdata, mis, strb, lanes, bmask, rd_exp);
      err_m = err_m | mis | (!mis & rerr);
      exp_stall = mis ? 1 : 3 + rl + sl;
      do_access(rd, wr, mask, addr, wdata, rl, sl, rdata, rerr, noise, o);
      checks++; if (!o.done) $display("FAIL rand%0d_done: got no completion expected completion", n); else passes++;
      checks++; if (o.stall_cycles != exp_stall) $display("FAIL rand%0d_stall: got %0d expected %0d", n, o.stall_cycles, exp_stall); else passes++;
      checks++; if (o.valid_cycles != (mis ? 0 : rl + 1)) $display("FAIL rand%0d_valid: got %0d expected %0d", n, o.valid_cycles, mis ? 0 : rl + 1); else passes++;
      checks++; if (o.rd_data !== rd_exp || o.rd_dirty) $display("FAIL rand%0d_rd_data: got %h dirty %b expected %h", n, o.rd_data, o.rd_dirty, rd_exp); else passes++;
      checks++; if (o.err !== err_m) $display("FAIL rand%0d_err: got %b expected %b", n, o.err, err_m); else passes++;
      if (!mis) begin
        checks++; if (o.addr !== {addr[31:2], 2'b00} || o.we !== wr)
          $display("FAIL rand%0d_req: got addr %h we %b expected %h %b", n, o.addr, o.we, {addr[31:2], 2'b00}, wr); else passes++;
        checks++; if (o.strb !== strb) $display("FAIL rand%0d_strb: got %b expected %b", n, o.strb, strb); else passes++;
        checks++; if (o.unstable) $display("FAIL rand%0d_stable: got payload change expected stable", n); else passes++;
        if (wr) begin
          checks++; if ((o.wdata & bmask) !== lanes)
            $display("FAIL rand%0d_wdata: got %h expected %h in lanes %h", n, o.wdata, lanes, bmask); else passes++;
        end
      end
    end
  endtask

`ifdef DMEM_RSP_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    apply_reset();
    do_access(1, 0, MASK_WORD, 32'h600, 32'h0, 0, 1000, 32'hFFFFFFFF, 0, 0, o);
    checks++; if (o.stall_cycles != 10) $display("FAIL timeout_stall: got %0d expected 10", o.stall_cycles); else passes++;
    checks++; if (o.err !== 1'b1) $display("FAIL timeout_err: got %b expected 1", o.err); else passes++;
    checks++; if (o.rd_data !== '0) $display("FAIL timeout_rd_data: got %h expected 0", o.rd_data); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misaligned();
    test_backpressure();
    test_both_enables();
    test_reset_mid();
    test_random();
`ifdef DMEM_RSP_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
